// File: rtl/custom_types_pkg.sv
// custom_types_pkg: types and constants shared by the fetch stage, its BTB and the decode stage
//   fetch_t     - fetch pipeline latch consumed by decode
//   btb_entry_t - one direct-mapped BTB entry (tag zero-extended to BTB_TAG_W bits)
package custom_types_pkg;

   localparam int BTB_TAG_W = 30;

   localparam logic [1:0] CTR_STRONG_NT = 2'b00;
   localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
   localparam logic [1:0] CTR_WEAK_T    = 2'b10;
   localparam logic [1:0] CTR_STRONG_T  = 2'b11;

   typedef struct packed {
      logic [31:0] imemload;
      logic [31:0] PC;
      logic [31:0] NPC;
      logic        branch_taken;
      logic [31:0] pred_branch_addr;
   } fetch_t;

   typedef struct packed {
      logic                 valid;
      logic [BTB_TAG_W-1:0] tag;
      logic [31:0]          target;
      logic [1:0]           ctr;
   } btb_entry_t;

endpackage

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters
//   CLK, nRST                           - clock, async active-low reset
//   pc -> predict, target               - combinational lookup
//   upd_en, upd_pc, upd_target, upd_taken - training from branch resolution
module branch_predictor
   import custom_types_pkg::*;
#(
   parameter int BTB_ENTRIES = 8,
   parameter int BTB_IDX_W   = $clog2(BTB_ENTRIES)
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] pc,
   output logic        predict,
   output logic [31:0] target,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken
);

   btb_entry_t btb [BTB_ENTRIES];

   logic [BTB_IDX_W-1:0] idx, uidx;
   logic [BTB_TAG_W-1:0] tag, utag;
   btb_entry_t           e, ue;
   logic                 uhit;
   logic                 unused_lsbs;

   // word-aligned fetch: the byte offset bits never take part in index or tag
   assign unused_lsbs = ^{pc[1:0], upd_pc[1:0]};

   assign idx     = pc[BTB_IDX_W+1:2];
   assign tag     = BTB_TAG_W'(pc[31:BTB_IDX_W+2]);
   assign e       = btb[idx];
   assign predict = e.valid && (e.tag == tag) && e.ctr[1];
   assign target  = e.target;

   assign uidx = upd_pc[BTB_IDX_W+1:2];
   assign utag = BTB_TAG_W'(upd_pc[31:BTB_IDX_W+2]);
   assign ue   = btb[uidx];
   assign uhit = ue.valid && (ue.tag == utag);

   // lookup reads the array directly, so a same-cycle update is seen only next cycle
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < BTB_ENTRIES; i++)
            btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};
      end else if (upd_en) begin
         if (uhit) begin
            btb[uidx].ctr <= upd_taken ? ((ue.ctr == CTR_STRONG_T) ? CTR_STRONG_T : ue.ctr + 2'd1)
                                       : ((ue.ctr == CTR_STRONG_NT) ? CTR_STRONG_NT : ue.ctr - 2'd1);
            if (upd_taken)
               btb[uidx].target <= upd_target;
         end else if (upd_taken) begin
            btb[uidx] <= '{valid: 1'b1, tag: utag, target: upd_target, ctr: CTR_WEAK_T};
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, instruction fetch request, BTB prediction and fetch latch
//   CLK, nRST                     - clock, async active-low reset
//   ihit, imemload, iREN, imemaddr - instruction memory interface
//   freeze, flush, halt           - hazard / halt control
//   redirect, redirect_pc         - PC correction from resolution
//   upd_*                         - BTB training
//   fetch_p                       - latch to decode
module fetch_stage
   import custom_types_pkg::*;
#(
   parameter logic [31:0] PC_INIT     = 32'h0000_0000,
   parameter int          BTB_ENTRIES = 8,
   parameter int          BTB_IDX_W   = $clog2(BTB_ENTRIES)
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] imemaddr,
   input  logic        freeze,
   input  logic        flush,
   input  logic        halt,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken,
   output fetch_t      fetch_p
);

   logic [31:0] pc, npc, pred_next, btb_target;
   logic        predict;

   branch_predictor #(.BTB_ENTRIES(BTB_ENTRIES), .BTB_IDX_W(BTB_IDX_W)) bp (
      .CLK(CLK),
      .nRST(nRST),
      .pc(pc),
      .predict(predict),
      .target(btb_target),
      .upd_en(upd_en),
      .upd_pc(upd_pc),
      .upd_target(upd_target),
      .upd_taken(upd_taken)
   );

   assign imemaddr  = pc;
   assign iREN      = ~halt;
   assign npc       = pc + 32'd4;
   assign pred_next = predict ? btb_target : npc;

   // redirect overrides freeze so a correction is never lost behind a stall
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         pc <= PC_INIT;
      else if (redirect)
         pc <= redirect_pc;
      else if (!freeze && ihit && !halt)
         pc <= pred_next;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         fetch_p <= '0;
      else if (flush && ihit)
         fetch_p <= '0;
      else if (!freeze && ihit)
         fetch_p <= '{imemload: imemload, PC: pc, NPC: npc, branch_taken: predict, pred_branch_addr: pred_next};
   end

endmodule
